sqr_pwm_gen: RTL and testbench
==============================

SQR_PWM_GEN -- requirements
Module: sqr_pwm_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 16: phase accumulator width.
REQ-002 SHALL have parameter FREQ_W, default 12: tuning word width (FREQ_W <= ACC_W).
REQ-003 SHALL have parameter PHASE_W, default 8: phase offset and duty width (PHASE_W <= ACC_W).
REQ-004 SHALL have parameter AMP_W, default 3: amplitude code width (AMP_W <= DAC_W-1).
REQ-005 SHALL have parameter DAC_W, default 14: DAC code width, offset binary.
REQ-006 SHALL have parameter CNT_W, default 16: burst length width.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port en, input, 1: enable; 0 forces IDLE.
REQ-010 SHALL have port mode, input, 1: 0 continuous, 1 burst.
REQ-011 SHALL have port start, input, 1: burst trigger, single-cycle pulse.
REQ-012 SHALL have port state_freq, input, FREQ_W: tuning word added per cycle.
REQ-013 SHALL have port state_amp, input, AMP_W: amplitude code.
REQ-014 SHALL have port state_phase, input, PHASE_W: phase offset.
REQ-015 SHALL have port state_duty, input, PHASE_W: high-time threshold.
REQ-016 SHALL have port burst_len, input, CNT_W: periods per burst.
REQ-017 SHALL have port DAC_in, output, DAC_W: registered DAC code.
REQ-018 SHALL have port busy, output, 1: high in RUN or BURST.
REQ-019 SHALL have port period_tick, output, 1: one-cycle pulse per accumulator wrap.

Function
REQ-020 SHALL implement states IDLE, RUN, BURST.
REQ-021 IDLE->RUN when en=1 and mode=0; IDLE->BURST when en=1, mode=1, start=1, burst_len!=0; start with burst_len=0 ignored.
REQ-022 SHALL leave RUN/BURST for IDLE on the cycle after en=0; en=0 has priority over start and wrap; rst overrides all.
REQ-023 In IDLE: accumulator cleared to 0, DAC_in = MID = 2^(DAC_W-1), period_tick=0.
REQ-024 In RUN/BURST: acc <= acc + zero-extended state_freq, mod 2^ACC_W, every cycle; wrap = carry out.
REQ-025 On entry to RUN/BURST and on every wrap, SHALL latch state_freq/amp/phase/duty into shadow registers; mid-period input changes take effect only at the next wrap.
REQ-026 Phase index p = (acc[ACC_W-1 -: PHASE_W] + shadow phase) mod 2^PHASE_W.
REQ-027 Output high when p < shadow duty; duty=0 gives constant low level.
REQ-028 step = (amp+1) << (DAC_W-1-AMP_W); high level = MID+step-1, low level = MID-step.
REQ-029 DAC_in SHALL be registered: value at cycle n+1 reflects acc and shadows at cycle n (1-cycle latency).
REQ-030 period_tick SHALL pulse the cycle after each wrap, in RUN and BURST.
REQ-031 BURST SHALL count wraps from burst_len down; after the burst_len-th wrap, return to IDLE next cycle.
REQ-032 start during RUN/BURST SHALL be ignored; mode changes SHALL take effect only in IDLE.
REQ-033 state_freq=0: accumulator holds, no wraps; burst never completes until en=0.

Reset
REQ-034 rst=1: state IDLE, acc=0, shadows=0, burst count=0, DAC_in=MID, busy=0, period_tick=0 on next edge.
REQ-035 rst mid-RUN/BURST SHALL abort with no further ticks; operation restarts per REQ-021 after rst falls.

Structure
REQ-036 Shared package sqr_pkg SHALL hold the state enum and MID/step helper functions.
REQ-037 Accumulator and wrap detect SHALL be sub-module phase_acc (params ACC_W, FREQ_W; ports clk, rst, clr, inc, acc, wrap).

Verification (bench params ACC_W=12, PHASE_W=8, AMP_W=3, DAC_W=14)
REQ-038 rst=1 for 2 cycles -> DAC_in=8192, busy=0, period_tick=0.
REQ-039 mode=0, freq=16, duty=128, amp=7, phase=0, en=1 -> repeating 128 cycles 16383 then 128 cycles 0; period_tick every 256 cycles.
REQ-040 As REQ-039 with phase=64 -> per period: 64 cycles 16383, 128 cycles 0, 64 cycles 16383.
REQ-041 duty 128->32 at cycle 50 of a period -> current period unchanged; next period 32 high, 224 low.
REQ-042 mode=1, burst_len=3, amp=0, start pulse -> exactly 3 periods (levels 9215/7168), 3 ticks, then busy=0, DAC_in=8192; second start mid-burst ignored.
REQ-043 en=0 mid-burst -> IDLE next cycle, DAC_in=8192 the cycle after, no further period_tick.

Source files
------------

// File: rtl/sqr_pkg.sv
// Shared types and level helpers for the square/PWM DAC generator.
// Level arithmetic is done in 32-bit unsigned; callers cast to DAC_W.
package sqr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } sqr_state_e;

  // Offset-binary midscale code, 2^(dac_w-1).
  function automatic logic [31:0] f_mid(input int unsigned dac_w);
    return 32'd1 << (dac_w - 32'd1);
  endfunction

  // Half-swing for an amplitude code: (amp+1) scaled into the upper DAC bits.
  function automatic logic [31:0] f_step(input logic [31:0] amp,
                                         input int unsigned amp_w,
                                         input int unsigned dac_w);
    return (amp + 32'd1) << (dac_w - 32'd1 - amp_w);
  endfunction

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator with carry-out wrap detect.
// wrap is the combinational carry of acc + inc for the current cycle.
module phase_acc #(
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned FREQ_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [FREQ_W-1:0] inc,
  output logic [ACC_W-1:0]  acc,
  output logic              wrap
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic [ACC_W:0] w_sum;

  assign w_sum = {1'b0, acc} + SUM_W'(inc);
  assign wrap  = w_sum[ACC_W];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else begin
      acc <= w_sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/sqr_pwm_gen.sv
// Square/PWM DAC generator: phase-accumulator timebase, continuous or burst mode.
// Frequency, amplitude, phase and duty are shadowed and only reloaded on entry and at wraps.
module sqr_pwm_gen
  import sqr_pkg::*;
#(
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned FREQ_W  = 12,
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned AMP_W   = 3,
  parameter int unsigned DAC_W   = 14,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               start,
  input  logic [FREQ_W-1:0]  state_freq,
  input  logic [AMP_W-1:0]   state_amp,
  input  logic [PHASE_W-1:0] state_phase,
  input  logic [PHASE_W-1:0] state_duty,
  input  logic [CNT_W-1:0]   burst_len,
  output logic [DAC_W-1:0]   DAC_in,
  output logic               busy,
  output logic               period_tick
);

  localparam logic [31:0]      MID      = f_mid(DAC_W);
  localparam logic [DAC_W-1:0] MID_CODE = DAC_W'(MID);

  sqr_state_e         r_state;
  sqr_state_e         w_state_nxt;
  logic [FREQ_W-1:0]  r_sh_freq;
  logic [AMP_W-1:0]   r_sh_amp;
  logic [PHASE_W-1:0] r_sh_phase;
  logic [PHASE_W-1:0] r_sh_duty;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [DAC_W-1:0]   r_dac;
  logic [DAC_W-1:0]   w_dac_nxt;
  logic               r_busy;
  logic               r_tick;
  logic               w_tick_nxt;
  logic               w_load;
  logic               w_clr;
  logic [ACC_W-1:0]   w_acc;
  logic               w_wrap;
  logic               w_active;
  logic               w_wrap_v;
  logic [PHASE_W-1:0] w_pidx;
  logic               w_high;
  logic [31:0]        w_step;
  logic [DAC_W-1:0]   w_lvl;

  phase_acc #(
    .ACC_W  (ACC_W),
    .FREQ_W (FREQ_W)
  ) u_phase_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .inc  (r_sh_freq),
    .acc  (w_acc),
    .wrap (w_wrap)
  );

  // Only the top PHASE_W accumulator bits address the waveform.
  if (ACC_W > PHASE_W) begin : g_acc_lsb
    logic w_unused_lsb;
    assign w_unused_lsb = ^w_acc[ACC_W-PHASE_W-1:0];
  end

  assign w_active = (r_state != ST_IDLE);
  assign w_wrap_v = w_active && w_wrap && en;

  // Waveform level for the current accumulator value and shadows.
  assign w_pidx = w_acc[ACC_W-1 -: PHASE_W] + r_sh_phase;
  assign w_high = (w_pidx < r_sh_duty);
  assign w_step = f_step(32'(r_sh_amp), AMP_W, DAC_W);
  assign w_lvl  = w_high ? DAC_W'(MID + w_step - 32'd1) : DAC_W'(MID - w_step);

  // Accumulator sits at zero in IDLE and is zeroed on any exit to IDLE.
  assign w_clr = (r_state == ST_IDLE) || (w_state_nxt == ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_tick_nxt  = 1'b0;
    w_dac_nxt   = MID_CODE;
    case (r_state)
      ST_IDLE: begin
        if (en && !mode) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end else if (en && mode && start && (burst_len != '0)) begin
          w_state_nxt = ST_BURST;
          w_load      = 1'b1;
          w_cnt_nxt   = burst_len;
        end
      end
      ST_RUN: begin
        w_dac_nxt = w_lvl;
        if (!en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_wrap_v) begin
          w_load     = 1'b1;
          w_tick_nxt = 1'b1;
        end
      end
      ST_BURST: begin
        w_dac_nxt = w_lvl;
        if (!en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_wrap_v) begin
          w_load     = 1'b1;
          w_tick_nxt = 1'b1;
          w_cnt_nxt  = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sh_freq  <= '0;
      r_sh_amp   <= '0;
      r_sh_phase <= '0;
      r_sh_duty  <= '0;
      r_cnt      <= '0;
      r_dac      <= MID_CODE;
      r_busy     <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dac   <= w_dac_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_tick  <= w_tick_nxt;
      if (w_load) begin
        r_sh_freq  <= state_freq;
        r_sh_amp   <= state_amp;
        r_sh_phase <= state_phase;
        r_sh_duty  <= state_duty;
      end
    end
  end

  assign DAC_in      = r_dac;
  assign busy        = r_busy;
  assign period_tick = r_tick;

endmodule

// File: tb/tb_sqr_pwm_gen.sv
// Self-checking bench for sqr_pwm_gen: directed waveform scenarios plus randomized
// traffic, all outputs compared every cycle against a cycle-level integer model.
module tb_sqr_pwm_gen;

  localparam int ACC_W   = 12;
  localparam int FREQ_W  = 12;
  localparam int PHASE_W = 8;
  localparam int AMP_W   = 3;
  localparam int DAC_W   = 14;
  localparam int CNT_W   = 16;
  localparam int MID     = 8192;

  logic               clk;
  logic               rst;
  logic               en;
  logic               mode;
  logic               start;
  logic [FREQ_W-1:0]  state_freq;
  logic [AMP_W-1:0]   state_amp;
  logic [PHASE_W-1:0] state_phase;
  logic [PHASE_W-1:0] state_duty;
  logic [CNT_W-1:0]   burst_len;
  logic [DAC_W-1:0]   DAC_in;
  logic               busy;
  logic               period_tick;

  sqr_pwm_gen #(
    .ACC_W   (ACC_W),
    .FREQ_W  (FREQ_W),
    .PHASE_W (PHASE_W),
    .AMP_W   (AMP_W),
    .DAC_W   (DAC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .start       (start),
    .state_freq  (state_freq),
    .state_amp   (state_amp),
    .state_phase (state_phase),
    .state_duty  (state_duty),
    .burst_len   (burst_len),
    .DAC_in      (DAC_in),
    .busy        (busy),
    .period_tick (period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_st: 0 idle, 1 continuous, 2 burst. Expected outputs are what the DUT
  // shows after the same rising edge.
  int m_st, m_acc, m_left;
  int s_f, s_a, s_p, s_d;
  int e_dac, e_busy, e_tick;
  bit m_valid = 1'b0;

  function automatic int level(input int acc, input int a, input int p, input int d);
    int idx, step;
    idx  = ((acc >> (ACC_W - PHASE_W)) + p) % (2 ** PHASE_W);
    step = (a + 1) * (2 ** (DAC_W - 1 - AMP_W));
    return (idx < d) ? (MID + step - 1) : (MID - step);
  endfunction

  task automatic latch_inputs();
    s_f = int'(state_freq);
    s_a = int'(state_amp);
    s_p = int'(state_phase);
    s_d = int'(state_duty);
  endtask

  always @(posedge clk) begin
    int nxt;
    bit wrapped;
    if (rst) begin
      m_st = 0; m_acc = 0; m_left = 0;
      s_f = 0; s_a = 0; s_p = 0; s_d = 0;
      e_dac = MID; e_busy = 0; e_tick = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      e_tick = 0;
      if (m_st == 0) begin
        e_dac = MID;
        m_acc = 0;
        if (en && !mode) begin
          m_st = 1;
          latch_inputs();
        end else if (en && mode && start && (burst_len != 0)) begin
          m_st = 2;
          latch_inputs();
          m_left = int'(burst_len);
        end
      end else begin
        e_dac   = level(m_acc, s_a, s_p, s_d);
        nxt     = m_acc + s_f;
        wrapped = (nxt >= 2 ** ACC_W);
        m_acc   = nxt % (2 ** ACC_W);
        if (!en) begin
          m_st  = 0;
          m_acc = 0;
        end else if (wrapped) begin
          e_tick = 1;
          latch_inputs();
          if (m_st == 2) begin
            m_left--;
            if (m_left == 0) begin
              m_st  = 0;
              m_acc = 0;
            end
          end
        end
      end
      e_busy = (m_st != 0) ? 1 : 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model dac", int'(DAC_in), e_dac);
      chk("model busy", int'(busy), e_busy);
      chk("model tick", int'(period_tick), e_tick);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (period_tick !== 1'b1 && k < 2000);
    chk(nm, int'(period_tick), 1);
  endtask

  task automatic check_run(input int len, input int val, input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (int'(DAC_in) != val) bad++;
    end
    chk({nm, " wrong-level cycles"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_n, lo_n, mid_n, tick_n, busy_n;
    rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0;
    state_freq = '0; state_amp = '0; state_phase = '0; state_duty = '0;
    burst_len = '0;

    // reset state
    cyc(2);
    chk("reset dac", int'(DAC_in), 8192);
    chk("reset busy", int'(busy), 0);
    chk("reset tick", int'(period_tick), 0);
    rst = 1'b0;
    cyc(3);

    // continuous 50% square, full amplitude
    state_freq = 12'd16; state_duty = 8'd128; state_amp = 3'd7;
    state_phase = 8'd0; mode = 1'b0; en = 1'b1;
    wait_tick("run first tick");
    check_run(128, 16383, "run high half");
    check_run(128, 0, "run low half");
    chk("run tick period 256", int'(period_tick), 1);

    // phase offset 64, applied at the next wrap
    state_phase = 8'd64;
    wait_tick("phase reload tick");
    check_run(64, 16383, "phase64 high head");
    check_run(128, 0, "phase64 low");
    check_run(64, 16383, "phase64 high tail");
    chk("phase64 tick", int'(period_tick), 1);

    // duty change mid-period only affects the following period
    state_phase = 8'd0;
    wait_tick("duty test tick");
    check_run(50, 16383, "duty pre-change");
    state_duty = 8'd32;
    check_run(78, 16383, "duty current period high");
    check_run(128, 0, "duty current period low");
    chk("duty tick 1", int'(period_tick), 1);
    check_run(32, 16383, "duty32 high");
    check_run(224, 0, "duty32 low");
    chk("duty tick 2", int'(period_tick), 1);

    // burst of 3 periods, minimum amplitude, with a second start mid-burst
    en = 1'b0;
    cyc(3);
    mode = 1'b1; state_amp = 3'd0; state_duty = 8'd128; burst_len = 16'd3; en = 1'b1;
    cyc(2);
    chk("burst idle before start", int'(busy), 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("burst busy at entry", int'(busy), 1);
    hi_n = 0; lo_n = 0; mid_n = 0; tick_n = 0; busy_n = 0;
    for (int i = 1; i < 900; i++) begin
      @(negedge clk);
      if (int'(DAC_in) == 9215) hi_n++;
      else if (int'(DAC_in) == 7168) lo_n++;
      else if (int'(DAC_in) == 8192) mid_n++;
      if (period_tick) tick_n++;
      if (busy) busy_n++;
      if (i == 768) begin
        chk("burst end busy", int'(busy), 0);
        chk("burst end last sample", int'(DAC_in), 7168);
        chk("burst end tick", int'(period_tick), 1);
      end
      if (i == 769) chk("burst end midscale", int'(DAC_in), 8192);
      if (i == 300) start = 1'b1;
      else if (i == 301) start = 1'b0;
    end
    chk("burst high samples", hi_n, 384);
    chk("burst low samples", lo_n, 384);
    chk("burst mid samples", mid_n, 131);
    chk("burst ticks", tick_n, 3);
    chk("burst busy cycles", busy_n, 767);

    // enable dropped mid-burst
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(100);
    chk("abort busy before", int'(busy), 1);
    en = 1'b0;
    cyc(1);
    chk("abort busy", int'(busy), 0);
    cyc(1);
    chk("abort midscale", int'(DAC_in), 8192);
    tick_n = 0; busy_n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (period_tick) tick_n++;
      if (busy) busy_n++;
    end
    chk("abort no ticks", tick_n, 0);
    chk("abort stays idle", busy_n, 0);

    // randomized traffic, checked by the model
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) < 3) en = ~en;
      else if ($urandom_range(0, 99) < 2) en = 1'b1;
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: state_freq = '0;
          1: state_freq = FREQ_W'($urandom_range(1, 64));
          2: state_freq = FREQ_W'($urandom_range(1024, 4095));
          default: state_freq = FREQ_W'($urandom_range(1, 4095));
        endcase
      end
      if ($urandom_range(0, 9) == 0) begin
        state_amp   = AMP_W'($urandom);
        state_phase = PHASE_W'($urandom);
        state_duty  = PHASE_W'($urandom);
      end
      if ($urandom_range(0, 9) == 0) burst_len = CNT_W'($urandom_range(0, 4));
    end
    rst = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
